ll_packet_arbiter: RTL and testbench

//  Shares the single 32-bit LocalLink write port of the Ethernet MAC TX FIFO between NUM_SRC packet sources.

---
 rtl/ll_packet_arbiter_pkg.sv | 15 +
 rtl/ll_skid_buf.sv | 64 ++++++
 rtl/ll_packet_arbiter.sv | 150 +++++++++++++++
 tb/tb_ll_packet_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ll_packet_arbiter_pkg.sv
// Shared LocalLink definitions for the packet arbiter and its skid buffer:
// flag bit positions, default widths and the arbiter state encoding.
package ll_packet_arbiter_pkg;

    localparam int LL_SOF_BIT = 0;
    localparam int LL_EOF_BIT = 1;
    localparam int LL_FLAGS_W = 4;
    localparam int LL_DATA_W  = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_e;

endpackage : ll_packet_arbiter_pkg

// File: rtl/ll_skid_buf.sv
// Two-entry LocalLink register slice: registered output and a ready that depends
// only on local occupancy, so downstream backpressure never reaches the input combinationally.
module ll_skid_buf
    import ll_packet_arbiter_pkg::*;
#(
    parameter int DATA_W  = LL_DATA_W,
    parameter int FLAGS_W = LL_FLAGS_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLAGS_W-1:0] i_flags,
    input  logic [DATA_W-1:0]  i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [FLAGS_W-1:0] o_flags,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_valid,
    input  logic               i_ready
);

    localparam int W = FLAGS_W + DATA_W;

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;

    logic [W-1:0] w_in;
    logic         w_push;
    logic         w_pop;

    assign w_in    = {i_flags, i_data};
    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;
    assign {o_flags, o_data} = r_head;

    // NOTE: the data slots are reset too, not just the count, because r_head drives
    // the output pins and those must read zero while reset is held.
    // NOTE: every register here is updated with <= so all reads see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= w_in;
                    else                 r_tail <= w_in;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                // Push and pop together only happens at occupancy 1.
                2'b11:   r_head <= w_in;
                default: ;
            endcase
        end
    end

endmodule : ll_skid_buf

// File: rtl/ll_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one LocalLink write port between
// NUM_SRC sources; the winner owns the port from SOF to EOF.
module ll_packet_arbiter
    import ll_packet_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = LL_DATA_W,
    parameter int FLAGS_W = LL_FLAGS_W,
    parameter int ERR_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC*FLAGS_W-1:0] src_flags_i,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data_i,
    input  logic [NUM_SRC-1:0]         src_src_rdy_i,
    output logic [NUM_SRC-1:0]         src_dst_rdy_o,
    output logic [FLAGS_W-1:0]         wr_flags_o,
    output logic [DATA_W-1:0]          wr_data_o,
    output logic                       wr_src_rdy_o,
    input  logic                       wr_dst_rdy_i,
    output logic [NUM_SRC-1:0]         grant_o,
    output logic                       busy_o,
    output logic [ERR_W-1:0]           err_cnt_o
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    state_e             r_state,   w_state_nxt;
    logic [NUM_SRC-1:0] r_grant,   w_grant_nxt;
    logic [IDX_W-1:0]   r_gidx,    w_gidx_nxt;
    logic [IDX_W-1:0]   r_rr_ptr,  w_rr_ptr_nxt;
    logic [ERR_W-1:0]   r_err_cnt, w_err_cnt_nxt;

    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_disc;
    logic [NUM_SRC-1:0] w_dst_rdy;
    logic               w_pick_found;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [FLAGS_W-1:0] w_g_flags;
    logic [DATA_W-1:0]  w_g_data;
    logic               w_g_valid;
    logic               w_int_rdy;
    logic               w_push;

    // NOTE: every always_comb assigns defaults first so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin : req_decode
        w_req  = '0;
        w_disc = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_req[k]  = src_src_rdy_i[k] &  src_flags_i[k*FLAGS_W + LL_SOF_BIT];
            w_disc[k] = src_src_rdy_i[k] & ~src_flags_i[k*FLAGS_W + LL_SOF_BIT];
        end
    end

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin : rr_pick
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_pick_found && w_req[(int'(r_rr_ptr) + i) % NUM_SRC]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = IDX_W'((int'(r_rr_ptr) + i) % NUM_SRC);
            end
        end
    end

    always_comb begin : granted_mux
        w_g_flags = '0;
        w_g_data  = '0;
        w_g_valid = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (r_grant[k]) begin
                w_g_flags = src_flags_i[k*FLAGS_W +: FLAGS_W];
                w_g_data  = src_data_i[k*DATA_W +: DATA_W];
                w_g_valid = src_src_rdy_i[k];
            end
        end
    end

    always_comb begin : fsm_next
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_gidx_nxt    = r_gidx;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_err_cnt_nxt = r_err_cnt;
        w_dst_rdy     = '0;
        w_push        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Mid-packet words seen while idle are swallowed and counted once per cycle.
                w_dst_rdy = w_disc;
                if ((|w_disc) && (r_err_cnt != '1)) w_err_cnt_nxt = r_err_cnt + 1'b1;
                if (w_pick_found) begin
                    w_state_nxt = ST_PASS;
                    w_grant_nxt = NUM_SRC'(1) << w_pick_idx;
                    w_gidx_nxt  = w_pick_idx;
                end
            end
            ST_PASS: begin
                w_dst_rdy = r_grant & {NUM_SRC{w_int_rdy}};
                w_push    = w_g_valid & w_int_rdy;
                if (w_push && w_g_flags[LL_EOF_BIT]) begin
                    w_state_nxt  = ST_IDLE;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = (r_gidx == IDX_W'(NUM_SRC - 1)) ? '0 : r_gidx + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_rr_ptr  <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_gidx    <= w_gidx_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    ll_skid_buf #(
        .DATA_W  (DATA_W),
        .FLAGS_W (FLAGS_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (reset),
        .i_flags (w_g_flags),
        .i_data  (w_g_data),
        .i_valid (w_push),
        .o_ready (w_int_rdy),
        .o_flags (wr_flags_o),
        .o_data  (wr_data_o),
        .o_valid (wr_src_rdy_o),
        .i_ready (wr_dst_rdy_i)
    );

    assign src_dst_rdy_o = w_dst_rdy;
    assign grant_o       = r_grant;
    assign err_cnt_o     = r_err_cnt;
    assign busy_o        = (r_state == ST_PASS) | wr_src_rdy_o;

endmodule : ll_packet_arbiter

// File: tb/tb_ll_packet_arbiter.sv
// Scoreboard bench for ll_packet_arbiter with two queue-driven sources and an
// output monitor comparing every delivered word against the expected order.
module tb_ll_packet_arbiter;

    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] data;
    } word_t;

    logic        clk;
    logic        reset;
    logic [7:0]  src_flags_i;
    logic [63:0] src_data_i;
    logic [1:0]  src_src_rdy_i;
    logic [1:0]  src_dst_rdy_o;
    logic [3:0]  wr_flags_o;
    logic [31:0] wr_data_o;
    logic        wr_src_rdy_o;
    logic        wr_dst_rdy_i;
    logic [1:0]  grant_o;
    logic        busy_o;
    logic [7:0]  err_cnt_o;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    word_t src_q[2][$];
    word_t exp_q[$];
    int    out_cyc_q[$];

    ll_packet_arbiter #(
        .NUM_SRC (2),
        .DATA_W  (32),
        .FLAGS_W (4),
        .ERR_W   (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .src_flags_i   (src_flags_i),
        .src_data_i    (src_data_i),
        .src_src_rdy_i (src_src_rdy_i),
        .src_dst_rdy_o (src_dst_rdy_o),
        .wr_flags_o    (wr_flags_o),
        .wr_data_o     (wr_data_o),
        .wr_src_rdy_o  (wr_src_rdy_o),
        .wr_dst_rdy_i  (wr_dst_rdy_i),
        .grant_o       (grant_o),
        .busy_o        (busy_o),
        .err_cnt_o     (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_pkt(input int src, input int len);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.flags[1:0] = {i == len - 1, i == 0};
            w.flags[3:2] = (len == 1) ? 2'b00 : 2'($urandom);
            w.data       = $urandom;
            src_q[src].push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic load_junk(input int src, input int n);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.flags = 4'b0000;
            w.data  = $urandom;
            src_q[src].push_back(w);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drain"}, n < budget, 1);
        exp_q.delete();
        src_q[0].delete();
        src_q[1].delete();
        repeat (3) step();
    endtask

    task automatic wait_exp_left(input string tag, input int left);
        int n = 0;
        while (exp_q.size() > left && n < 200) begin
            step();
            n++;
        end
        check({tag, "_reach"}, n < 200, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        src_q[0].delete();
        src_q[1].delete();
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    // Source models: present queue head, pop on the transfer seen before the edge.
    initial begin : drv
        logic [1:0] xfer;
        src_src_rdy_i = '0;
        src_flags_i   = '0;
        src_data_i    = '0;
        forever begin
            @(negedge clk);
            xfer = src_src_rdy_i & src_dst_rdy_o;
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (reset && xfer[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
                if (reset && src_q[k].size() != 0) begin
                    src_src_rdy_i[k]       = 1'b1;
                    src_flags_i[k*4 +: 4]  = src_q[k][0].flags;
                    src_data_i[k*32 +: 32] = src_q[k][0].data;
                end else begin
                    src_src_rdy_i[k]       = 1'b0;
                    src_flags_i[k*4 +: 4]  = '0;
                    src_data_i[k*32 +: 32] = '0;
                end
            end
        end
    end

    initial begin : mon
        word_t e;
        forever begin
            @(negedge clk);
            if (reset && wr_src_rdy_o && wr_dst_rdy_i) begin
                out_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {wr_flags_o, wr_data_o}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {wr_flags_o, wr_data_o}, e);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int          req;
        int          acc;
        logic [35:0] held;

        reset        = 1'b0;
        wr_dst_rdy_i = 1'b1;
        repeat (3) step();
        check("rst_wr_src_rdy", wr_src_rdy_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_cnt_o, 0);
        check("rst_wr_word", {wr_flags_o, wr_data_o}, 0);
        check("rst_dst_rdy", src_dst_rdy_o, 0);
        reset = 1'b1;
        step();

        // 1: single 16-word packet from src0
        out_cyc_q.delete();
        req = cyc + 1;
        load_pkt(0, 16);
        step();
        check("t1_grant_arb", grant_o, 2'b00);
        step();
        check("t1_grant", grant_o, 2'b01);
        check("t1_busy", busy_o, 1);
        drain("t1", 200);
        check("t1_count", out_cyc_q.size(), 16);
        check("t1_latency", out_cyc_q[0] - req, 2);
        check("t1_stream", out_cyc_q[15] - out_cyc_q[0], 15);
        check("t1_grant_end", grant_o, 2'b00);
        check("t1_busy_end", busy_o, 0);

        // 2: simultaneous requests with rr_ptr=0, two rounds
        do_reset();
        out_cyc_q.delete();
        load_pkt(0, 8);
        load_pkt(1, 8);
        load_pkt(0, 8);
        load_pkt(1, 8);
        repeat (2) step();
        check("t2_first_grant", grant_o, 2'b01);
        drain("t2", 400);
        check("t2_count", out_cyc_q.size(), 32);
        check("t2_gap_ab", out_cyc_q[8] - out_cyc_q[7], 2);
        check("t2_gap_bc", out_cyc_q[16] - out_cyc_q[15], 2);
        check("t2_gap_cd", out_cyc_q[24] - out_cyc_q[23], 2);

        // 3: 10-cycle output pause mid-packet
        load_pkt(0, 16);
        wait_exp_left("t3", 11);
        wr_dst_rdy_i = 1'b0;
        acc  = 0;
        held = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) held = {wr_flags_o, wr_data_o};
            else        check("t3_hold", {wr_flags_o, wr_data_o}, held);
            acc += int'(src_src_rdy_i[0] & src_dst_rdy_o[0]);
        end
        check("t3_valid_held", wr_src_rdy_o, 1);
        check("t3_stall", src_dst_rdy_o[0], 0);
        check("t3_acc_le2", acc <= 2, 1);
        @(posedge clk);
        #2;
        wr_dst_rdy_i = 1'b1;
        drain("t3", 200);

        // 4: discarded non-SOF words and counter saturation
        check("t4_err0", err_cnt_o, 8'd0);
        load_junk(1, 1);
        drain("t4a", 50);
        check("t4_err1", err_cnt_o, 8'd1);
        load_junk(0, 1);
        load_junk(1, 1);
        drain("t4b", 50);
        check("t4_err_pair", err_cnt_o, 8'd2);
        load_junk(1, 300);
        drain("t4c", 1000);
        check("t4_err_sat", err_cnt_o, 8'hFF);
        check("t4_busy", busy_o, 0);

        // 5: 1-word packet from src1 then a src0 packet
        out_cyc_q.delete();
        load_pkt(1, 1);
        step();
        load_pkt(0, 16);
        drain("t5", 200);
        check("t5_count", out_cyc_q.size(), 17);
        check("t5_gap", out_cyc_q[1] - out_cyc_q[0], 2);

        // 6: reset at word 7 of a packet
        load_pkt(0, 16);
        wait_exp_left("t6", 9);
        reset = 1'b0;
        #1;
        check("t6_wr_src_rdy", wr_src_rdy_o, 0);
        check("t6_grant", grant_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_err", err_cnt_o, 0);
        exp_q.delete();
        src_q[0].delete();
        src_q[1].delete();
        repeat (2) step();
        reset = 1'b1;
        step();
        load_pkt(0, 4);
        load_pkt(1, 4);
        repeat (2) step();
        check("t6_rr_grant", grant_o, 2'b01);
        drain("t6", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ll_packet_arbiter
